data_mem_responder: RTL and testbench

Word-organised data memory that acts as the responder end of the pipeline's load/store request interface. It sits behind the MEM stage. It accepts one request per valid/ready handshake, inserts a configurable number of wait states, then returns a response that is held until the requester accepts it. It supports byte-enabled writes, so the pipeline can later stall on memory latency instead of assuming single-cycle RAM.

---
 rtl/data_mem_responder.sv | 214 +++++++++++++++++++++
 tb/tb_data_mem_responder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder
// Word-organised data memory acting as the responder end of the load/store
// request interface behind the MEM stage. Each request is accepted on a
// valid/ready handshake. After LATENCY wait states the access commits, and the
// response is held until the requester accepts it. Stores honour byte enables.
//
// Optional build macro: MEM_ERR_EN
//   When defined, an RSP_ERR output is added. It flags out-of-range or
//   misaligned accesses, and such accesses neither write nor return data.
//   When undefined, address bits [1:0] are ignored and out-of-range accesses
//   complete quietly: loads return 0 and stores are dropped.

module data_mem_responder #(
   parameter int ADDR_W  = 9,
   parameter int DEPTH   = 512,
   parameter int LATENCY = 2
) (
   input  logic        CLOCK,
   input  logic        RESET,
   input  logic        REQ_VALID,
   output logic        REQ_READY,
   input  logic        REQ_WRITE,
   input  logic [31:0] REQ_ADDR,
   input  logic [31:0] REQ_WDATA,
   input  logic [3:0]  REQ_BE,
   output logic        RSP_VALID,
   input  logic        RSP_READY,
   output logic [31:0] RSP_RDATA,
   output logic        BUSY
`ifdef MEM_ERR_EN
   ,
   output logic        RSP_ERR
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [31:0] DEPTH_W  = 32'(DEPTH);
   localparam logic [3:0]  LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   state_t        state;
   state_t        state_next;
   logic [3:0]    wait_cnt;

   logic          lat_write;
   logic [31:0]   lat_addr;
   logic [31:0]   lat_wdata;
   logic [3:0]    lat_be;

   logic          req_ready_c;
   logic          accept;
   logic          commit;

   logic          acc_write;
   logic [31:0]   acc_addr;
   logic [31:0]   acc_wdata;
   logic [3:0]    acc_be;
   logic [ADDR_W-1:0] acc_idx;
   logic [31:0]   acc_word;
   logic          acc_in_range;
   logic          acc_ok;

   logic [31:0]   rsp_rdata_q;
   logic [31:0]   mem [DEPTH];

   // State register; a reset also abandons any request that is in flight.
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. Requests are accepted in IDLE only, so no new request can overlap a response.
   always_comb begin
      state_next  = state;
      req_ready_c = 1'b0;
      accept      = 1'b0;
      commit      = 1'b0;
      case (state)
         IDLE: begin
            req_ready_c = 1'b1;
            if (REQ_VALID) begin
               accept = 1'b1;
               if (LATENCY == 0) begin
                  commit     = 1'b1;
                  state_next = RESP;
               end else begin
                  state_next = WAIT;
               end
            end
         end
         WAIT: begin
            if (wait_cnt == 4'd0) begin
               commit     = 1'b1;
               state_next = RESP;
            end
         end
         RESP: begin
            if (RSP_READY) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // With zero latency the access commits on the acceptance edge, so it must use the live request rather than the latched copy.
   always_comb begin
      if (state == IDLE) begin
         acc_write = REQ_WRITE;
         acc_addr  = REQ_ADDR;
         acc_wdata = REQ_WDATA;
         acc_be    = REQ_BE;
      end else begin
         acc_write = lat_write;
         acc_addr  = lat_addr;
         acc_wdata = lat_wdata;
         acc_be    = lat_be;
      end
   end

   // The range check uses the full word address, so high address bits cannot alias onto low words.
   assign acc_idx      = acc_addr[ADDR_W+1:2];
   assign acc_word     = {2'b00, acc_addr[31:2]};
   assign acc_in_range = (acc_word < DEPTH_W);

`ifdef MEM_ERR_EN
   assign acc_ok = acc_in_range && (acc_addr[1:0] == 2'b00);
`else
   logic unused_addr_bits;
   assign unused_addr_bits = ^acc_addr[1:0];
   assign acc_ok = acc_in_range;
`endif

   // Capture the request on acceptance, and count down the wait states while a request is in WAIT.
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         lat_write <= 1'b0;
         lat_addr  <= 32'd0;
         lat_wdata <= 32'd0;
         lat_be    <= 4'd0;
         wait_cnt  <= 4'd0;
      end else begin
         if (accept) begin
            lat_write <= REQ_WRITE;
            lat_addr  <= REQ_ADDR;
            lat_wdata <= REQ_WDATA;
            lat_be    <= REQ_BE;
         end
         if (accept && (LATENCY > 0)) begin
            wait_cnt <= LAT_LOAD;
         end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
         end
      end
   end

   // Response data is loaded once at commit and held unchanged until the handshake; stores and rejected accesses return zero.
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         rsp_rdata_q <= 32'd0;
      end else if (commit) begin
         if (!acc_write && acc_ok) begin
            rsp_rdata_q <= mem[acc_idx];
         end else begin
            rsp_rdata_q <= 32'd0;
         end
      end
   end

`ifdef MEM_ERR_EN
   logic rsp_err_q;

   // The error flag is decided at commit, at the same time as the response data.
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         rsp_err_q <= 1'b0;
      end else if (commit) begin
         rsp_err_q <= ~acc_ok;
      end
   end

   assign RSP_ERR = rsp_err_q;
`endif

   // Memory array. Reset clears every word, and a store updates only its enabled bytes at commit.
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         for (int w = 0; w < DEPTH; w++) begin
            mem[w] <= 32'd0;
         end
      end else if (commit && acc_write && acc_ok) begin
         for (int b = 0; b < 4; b++) begin
            if (acc_be[b]) begin
               mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
            end
         end
      end
   end

   assign REQ_READY = req_ready_c & RESET;
   assign RSP_VALID = (state == RESP);
   assign RSP_RDATA = rsp_rdata_q;
   assign BUSY      = (state != IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
// Directed stimulus for data_mem_responder. Each request pushes its expected
// response into a scoreboard queue. A monitor pops the queue and compares the
// response whenever a response handshake takes place.
// The out-of-range and misaligned checks follow the MEM_ERR_EN macro.

module tb_data_mem_responder;

   localparam int LAT = 2;

   typedef struct packed {
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic        CLOCK;
   logic        RESET;
   logic        REQ_VALID;
   logic        REQ_READY;
   logic        REQ_WRITE;
   logic [31:0] REQ_ADDR;
   logic [31:0] REQ_WDATA;
   logic [3:0]  REQ_BE;
   logic        RSP_VALID;
   logic        RSP_READY;
   logic [31:0] RSP_RDATA;
   logic        BUSY;
`ifdef MEM_ERR_EN
   logic        RSP_ERR;
`endif

   exp_t sb[$];
   int   check_cnt = 0;
   int   pass_cnt  = 0;

   data_mem_responder #(
      .ADDR_W  (9),
      .DEPTH   (512),
      .LATENCY (LAT)
   ) dut (
      .CLOCK     (CLOCK),
      .RESET     (RESET),
      .REQ_VALID (REQ_VALID),
      .REQ_READY (REQ_READY),
      .REQ_WRITE (REQ_WRITE),
      .REQ_ADDR  (REQ_ADDR),
      .REQ_WDATA (REQ_WDATA),
      .REQ_BE    (REQ_BE),
      .RSP_VALID (RSP_VALID),
      .RSP_READY (RSP_READY),
      .RSP_RDATA (RSP_RDATA),
      .BUSY      (BUSY)
`ifdef MEM_ERR_EN
      ,
      .RSP_ERR   (RSP_ERR)
`endif
   );

   // 10-unit clock period.
   initial begin
      CLOCK = 1'b0;
      forever #5 CLOCK = ~CLOCK;
   end

   // Stop the run if the bench itself stalls.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      check_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: pops one expected response per response handshake.
   always @(negedge CLOCK) begin
      exp_t e;
      if (RESET && RSP_VALID && RSP_READY) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_rsp", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            checkOutput("rsp_rdata", RSP_RDATA, e.data);
`ifdef MEM_ERR_EN
            checkOutput("rsp_err", {31'd0, RSP_ERR}, {31'd0, e.err});
`endif
         end
      end
   end

   // Drive one request, push its expected response, then measure when RSP_VALID rises.
   task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] be, input logic [31:0] exp_data, input logic exp_err);
      int   cyc;
      exp_t e;
      @(posedge CLOCK); #1;
      REQ_VALID = 1'b1;
      REQ_WRITE = wr;
      REQ_ADDR  = addr;
      REQ_WDATA = wdata;
      REQ_BE    = be;
      cyc = 0;
      @(negedge CLOCK);
      while (!REQ_READY && cyc < 50) begin
         @(negedge CLOCK);
         cyc++;
      end
      checkOutput("req_ready", {31'd0, REQ_READY}, 32'd1);
      e.data = exp_data;
      e.err  = exp_err;
      sb.push_back(e);
      @(posedge CLOCK); #1;
      REQ_VALID = 1'b0;
      cyc = 0;
      @(negedge CLOCK);
      while (!RSP_VALID && cyc < 50) begin
         @(negedge CLOCK);
         cyc++;
      end
      checkOutput("rsp_latency", 32'(cyc), 32'(LAT));
   endtask

   // Main directed sequence.
   initial begin
      logic        err_exp;
      logic [31:0] mis_data;
      RESET     = 1'b0;
      REQ_VALID = 1'b0;
      REQ_WRITE = 1'b0;
      REQ_ADDR  = 32'd0;
      REQ_WDATA = 32'd0;
      REQ_BE    = 4'd0;
      RSP_READY = 1'b1;
`ifdef MEM_ERR_EN
      err_exp  = 1'b1;
      mis_data = 32'h0000_0000;
`else
      err_exp  = 1'b0;
      mis_data = 32'hDEAD_BEEF;
`endif

      // reset and idle
      repeat (2) @(posedge CLOCK);
      @(negedge CLOCK);
      checkOutput("ready_in_reset", {31'd0, REQ_READY}, 32'd0);
      @(posedge CLOCK); #1;
      RESET = 1'b1;
      @(negedge CLOCK);
      checkOutput("idle_rsp_valid", {31'd0, RSP_VALID}, 32'd0);
      checkOutput("idle_busy", {31'd0, BUSY}, 32'd0);
      checkOutput("idle_req_ready", {31'd0, REQ_READY}, 32'd1);
      applyStimulus(1'b0, 32'h10, 32'd0, 4'h0, 32'h0, 1'b0);

      // store then load
      applyStimulus(1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
      checkOutput("busy_in_resp", {31'd0, BUSY}, 32'd1);
      applyStimulus(1'b0, 32'h40, 32'd0, 4'h0, 32'hDEAD_BEEF, 1'b0);

      // byte enables
      applyStimulus(1'b1, 32'h80, 32'h1122_3344, 4'hF, 32'h0, 1'b0);
      applyStimulus(1'b1, 32'h80, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0);
      applyStimulus(1'b0, 32'h80, 32'd0, 4'h0, 32'h11BB_33DD, 1'b0);
      applyStimulus(1'b1, 32'h80, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0);
      applyStimulus(1'b0, 32'h80, 32'd0, 4'h0, 32'h11BB_33DD, 1'b0);

      // response backpressure
      @(posedge CLOCK); #1;
      RSP_READY = 1'b0;
      applyStimulus(1'b0, 32'h40, 32'd0, 4'h0, 32'hDEAD_BEEF, 1'b0);
      for (int i = 0; i < 5; i++) begin
         checkOutput("bp_rsp_valid", {31'd0, RSP_VALID}, 32'd1);
         checkOutput("bp_rsp_rdata", RSP_RDATA, 32'hDEAD_BEEF);
         checkOutput("bp_req_ready", {31'd0, REQ_READY}, 32'd0);
         @(negedge CLOCK);
      end
      @(posedge CLOCK); #1;
      RSP_READY = 1'b1;
      @(negedge CLOCK);
      @(negedge CLOCK);
      checkOutput("bp_release_busy", {31'd0, BUSY}, 32'd0);
      checkOutput("bp_release_ready", {31'd0, REQ_READY}, 32'd1);

      // top in-range word
      applyStimulus(1'b1, 32'h7FC, 32'h55AA_55AA, 4'hF, 32'h0, 1'b0);
      applyStimulus(1'b0, 32'h7FC, 32'd0, 4'h0, 32'h55AA_55AA, 1'b0);

      // out of range and misaligned
      applyStimulus(1'b1, 32'h800, 32'hCAFE_F00D, 4'hF, 32'h0, err_exp);
      applyStimulus(1'b0, 32'h800, 32'd0, 4'h0, 32'h0, err_exp);
      applyStimulus(1'b0, 32'h0, 32'd0, 4'h0, 32'h0, 1'b0);
      applyStimulus(1'b0, 32'h40, 32'd0, 4'h0, 32'hDEAD_BEEF, 1'b0);
      applyStimulus(1'b0, 32'h7FC, 32'd0, 4'h0, 32'h55AA_55AA, 1'b0);
      applyStimulus(1'b0, 32'h41, 32'd0, 4'h0, mis_data, err_exp);

      // reset during WAIT abandons the store
      @(posedge CLOCK); #1;
      REQ_VALID = 1'b1;
      REQ_WRITE = 1'b1;
      REQ_ADDR  = 32'hC0;
      REQ_WDATA = 32'h1234_5678;
      REQ_BE    = 4'hF;
      @(negedge CLOCK);
      checkOutput("wait_req_ready", {31'd0, REQ_READY}, 32'd1);
      @(posedge CLOCK); #1;
      REQ_VALID = 1'b0;
      @(negedge CLOCK);
      checkOutput("wait_busy", {31'd0, BUSY}, 32'd1);
      #1 RESET = 1'b0;
      #1;
      checkOutput("wait_reset_busy", {31'd0, BUSY}, 32'd0);
      @(posedge CLOCK); #1;
      RESET = 1'b1;
      applyStimulus(1'b0, 32'hC0, 32'd0, 4'h0, 32'h0, 1'b0);

      // reset during RESP drops RSP_VALID without a clock edge
      @(posedge CLOCK); #1;
      RSP_READY = 1'b0;
      applyStimulus(1'b0, 32'h40, 32'd0, 4'h0, 32'h0, 1'b0);
      checkOutput("resp_valid_before_reset", {31'd0, RSP_VALID}, 32'd1);
      #2 RESET = 1'b0;
      sb.delete();
      #1;
      checkOutput("rsp_valid_async_drop", {31'd0, RSP_VALID}, 32'd0);
      RSP_READY = 1'b1;
      @(posedge CLOCK); #1;
      RESET = 1'b1;
      applyStimulus(1'b0, 32'h40, 32'd0, 4'h0, 32'h0, 1'b0);

      repeat (3) @(negedge CLOCK);
      checkOutput("scoreboard_drain", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
